id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register, directly downstream of the register file.
- Captures the register file's rs/rt read data plus the decoded immediate and control word, and holds them for the execute stage.
- Detects load-use hazards: issues a one-cycle stall to PC and IF/ID, and inserts a bubble.
- Handles branch flushes and keeps saturating stall/flush event counters for debug.

---
 rtl/id_ex_stage.sv | 82 ++++++++
 tb/tb_id_ex_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating debug counters for stall and flush cycles.
module id_ex_stage #(
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_dest_addr,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int MEM_READ_BIT = 1;
  localparam int REG_DST_BIT  = 5;

  logic haz;

  // A load into $0 never produces a usable value, so it cannot cause a hazard.
  always_comb begin
    haz = ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rt_addr != 5'd0) & id_valid &
          ((ex_rt_addr == id_rs_addr) | (ex_rt_addr == id_rt_addr));
    stall = haz & ~ex_flush & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_dest_addr <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else if (ex_flush || stall) begin
      // Flush and stall both load a bubble; flush has priority for counting.
      ex_valid     <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_dest_addr <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      if (ex_flush) begin
        if (flush_count != '1) flush_count <= flush_count + 1'b1;
      end else begin
        if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end
    end else begin
      ex_valid     <= id_valid;
      ex_rs_addr   <= id_rs_addr;
      ex_rt_addr   <= id_rt_addr;
      ex_dest_addr <= id_ctrl[REG_DST_BIT] ? id_rd_addr : id_rt_addr;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle expectations are pushed to a
// scoreboard queue at drive time and popped after the capturing edge.
module tb_id_ex_stage;

  localparam int CTRL_W = 10;
  localparam int CNT_W  = 4;

  localparam logic [9:0] C_LW   = 10'h01B;
  localparam logic [9:0] C_ADD  = 10'h0A1;
  localparam logic [9:0] C_RD   = 10'h021;
  localparam logic [9:0] C_RT   = 10'h001;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [4:0]        id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0]       id_rs_data, id_rt_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_flush;
  logic              stall, ex_valid;
  logic [4:0]        ex_rs_addr, ex_rt_addr, ex_dest_addr;
  logic [31:0]       ex_rs_data, ex_rt_data, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_count, flush_count;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [9:0]  ctrl;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dest_addr(ex_dest_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: check combinational stall, advance the model,
  // then compare the registered outputs against the popped expectation.
  task automatic cyc(input logic r, input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic [31:0] imm, input logic [9:0] ctrl,
                     input logic fl);
    logic st;
    exp_t e;
    rst = r; id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl; ex_flush = fl;
    #1;
    st = !r && !fl && m.valid && m.ctrl[1] && (m.rt != 5'd0) && v &&
         ((m.rt == rs) || (m.rt == rt));
    chk("stall", {31'd0, stall}, {31'd0, st});
    if (r) begin
      m = '0;
    end else if (fl || st) begin
      m.valid = 1'b0; m.rs = '0; m.rt = '0; m.dest = '0;
      m.rsd = '0; m.rtd = '0; m.imm = '0; m.ctrl = '0;
      if (fl) m.fc = (m.fc == 4'hF) ? 4'hF : m.fc + 4'd1;
      else    m.sc = (m.sc == 4'hF) ? 4'hF : m.sc + 4'd1;
    end else begin
      m.valid = v; m.rs = rs; m.rt = rt; m.dest = ctrl[5] ? rd : rt;
      m.rsd = rsd; m.rtd = rtd; m.imm = imm; m.ctrl = v ? ctrl : 10'd0;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("ex_valid",     {31'd0, ex_valid}, {31'd0, e.valid});
      chk("ex_rs_addr",   {27'd0, ex_rs_addr}, {27'd0, e.rs});
      chk("ex_rt_addr",   {27'd0, ex_rt_addr}, {27'd0, e.rt});
      chk("ex_dest_addr", {27'd0, ex_dest_addr}, {27'd0, e.dest});
      chk("ex_rs_data",   ex_rs_data, e.rsd);
      chk("ex_rt_data",   ex_rt_data, e.rtd);
      chk("ex_imm",       ex_imm, e.imm);
      chk("ex_ctrl",      {22'd0, ex_ctrl}, {22'd0, e.ctrl});
      chk("stall_count",  {28'd0, stall_count}, {28'd0, e.sc});
      chk("flush_count",  {28'd0, flush_count}, {28'd0, e.fc});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = '0;
    // Reset with busy inputs
    cyc(1, 1, 5'd7, 5'd8, 5'd9, 32'hAA, 32'hBB, 32'hCC, C_LW, 0);
    cyc(1, 1, 5'd7, 5'd8, 5'd9, 32'hAA, 32'hBB, 32'hCC, C_LW, 0);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ctrl", {22'd0, ex_ctrl}, 32'd0);

    // Pass-through, reg_dst=1 then reg_dst=0
    cyc(0, 1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFF0, C_RD, 0);
    chk("pt_dest_rd", {27'd0, ex_dest_addr}, 32'd5);
    chk("pt_imm", ex_imm, 32'hFFFF_FFF0);
    cyc(0, 1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFF0, C_RT, 0);
    chk("pt_dest_rt", {27'd0, ex_dest_addr}, 32'd4);

    // Invalid decode slot clears ctrl
    cyc(0, 0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, C_ADD, 0);
    chk("invalid_ctrl", {22'd0, ex_ctrl}, 32'd0);

    // Load-use on $8: one stall, then the add is captured
    cyc(0, 1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW, 0);
    cyc(0, 1, 5'd8, 5'd2, 5'd10, 32'h33, 32'h44, 32'h0, C_ADD, 0);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_count", {28'd0, stall_count}, 32'd1);
    cyc(0, 1, 5'd8, 5'd2, 5'd10, 32'h33, 32'h44, 32'h0, C_ADD, 0);
    chk("lu_capture_dest", {27'd0, ex_dest_addr}, 32'd10);

    // Load into $0 then use $0: no stall
    cyc(0, 1, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, C_LW, 0);
    cyc(0, 1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, C_ADD, 0);
    // Load into $8 then use $9: no stall
    cyc(0, 1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW, 0);
    cyc(0, 1, 5'd9, 5'd9, 5'd12, 32'h1, 32'h2, 32'h0, C_ADD, 0);
    chk("nostall_count", {28'd0, stall_count}, 32'd1);

    // Hazard coincident with flush: flush wins
    cyc(0, 1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW, 0);
    cyc(0, 1, 5'd8, 5'd8, 5'd13, 32'h1, 32'h2, 32'h0, C_ADD, 1);
    chk("fh_flush_count", {28'd0, flush_count}, 32'd1);
    chk("fh_stall_count", {28'd0, stall_count}, 32'd1);

    // Reset during a would-be stall, then normal capture
    cyc(0, 1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW, 0);
    cyc(1, 1, 5'd8, 5'd2, 5'd14, 32'h1, 32'h2, 32'h0, C_ADD, 0);
    cyc(0, 1, 5'd8, 5'd2, 5'd14, 32'h1, 32'h2, 32'h0, C_ADD, 0);
    chk("post_reset_valid", {31'd0, ex_valid}, 32'd1);
    chk("post_reset_dest", {27'd0, ex_dest_addr}, 32'd14);

    // Twenty flushes saturate the 4-bit counter
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 5'd1, 5'd2, 5'd3, i, 32'h2, 32'h3, C_ADD, 1);
    chk("flush_sat", {28'd0, flush_count}, 32'd15);
    cyc(0, 1, 5'd1, 5'd2, 5'd3, 32'h9, 32'h2, 32'h3, C_ADD, 0);
    chk("flush_sat_hold", {28'd0, flush_count}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
